// File: rtl/field_types_top.sv
// field_types_top: APB4 register block with ten
// 8-bit fields, one per sw/hw access combination.
module field_types_top #(
  parameter int G_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_apb_psel,
  input  logic                    s_apb_penable,
  input  logic                    s_apb_pwrite,
  input  logic [2:0]              s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic [31:0]             s_apb_pwdata,
  input  logic [3:0]              s_apb_pstrb,
  output logic                    s_apb_pready,
  output logic [31:0]             s_apb_prdata,
  output logic                    s_apb_pslverr,
  input  logic [7:0]              hwif_in_r1_f_next,
  input  logic                    hwif_in_r1_f_we,
  output logic [7:0]              hwif_out_r1_f_value,
  output logic [7:0]              hwif_out_r2_f_value,
  input  logic [7:0]              hwif_in_r3_f_next,
  input  logic                    hwif_in_r3_f_wel,
  input  logic [7:0]              hwif_in_r5_f_next,
  input  logic                    hwif_in_r5_f_we,
  output logic [7:0]              hwif_out_r5_f_value,
  output logic [7:0]              hwif_out_r6_f_value,
  input  logic [7:0]              hwif_in_r7_f_next,
  input  logic [7:0]              hwif_in_r9_f_next,
  input  logic                    hwif_in_r9_f_we,
  output logic [7:0]              hwif_out_r9_f_value,
  output logic [7:0]              hwif_out_r10_f_value
);

  localparam logic [7:0] RST_R1  = 8'd10;
  localparam logic [7:0] RST_R2  = 8'd20;
  localparam logic [7:0] RST_R3  = 8'd30;
  localparam logic [7:0] RST_R4  = 8'd40;
  localparam logic [7:0] RST_R5  = 8'd50;
  localparam logic [7:0] CONST_R6 = 8'd60;
  localparam logic [7:0] CONST_R8 = 8'd80;
  localparam logic [7:0] RST_R9  = 8'd90;
  localparam logic [7:0] RST_R10 = 8'd100;

  logic       setup_q;
  logic       access;
  logic       sw_wr;
  logic       sw_rd;
  logic [7:0] wdata;
  logic [9:0] sel;
  logic [7:0] rd_mux;

  logic [7:0] r1_q;
  logic [7:0] r2_q;
  logic [7:0] r3_q;
  logic [7:0] r4_q;
  logic [7:0] r5_q;
  logic [7:0] r9_q;
  logic [7:0] r10_q;

  logic unused_bits;
  assign unused_bits = ^{s_apb_pprot,
                         s_apb_pwdata[31:8],
                         s_apb_pstrb[3:1]};

  // Remember that the previous cycle was a setup phase;
  // reset clears it so an interrupted transfer never completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      setup_q <= 1'b0;
    end else begin
      setup_q <= s_apb_psel & ~s_apb_penable;
    end
  end

  assign access = s_apb_psel & s_apb_penable
                & setup_q & ~rst;
  assign sw_wr  = access & s_apb_pwrite
                & s_apb_pstrb[0];
  assign sw_rd  = access & ~s_apb_pwrite;
  assign wdata  = s_apb_pwdata[7:0];

  // One-hot register select from the byte address.
  always_comb begin
    sel = '0;
    case (s_apb_paddr)
      G_ADDR_WIDTH'(0): sel[0] = 1'b1;
      G_ADDR_WIDTH'(1): sel[1] = 1'b1;
      G_ADDR_WIDTH'(2): sel[2] = 1'b1;
      G_ADDR_WIDTH'(3): sel[3] = 1'b1;
      G_ADDR_WIDTH'(4): sel[4] = 1'b1;
      G_ADDR_WIDTH'(5): sel[5] = 1'b1;
      G_ADDR_WIDTH'(6): sel[6] = 1'b1;
      G_ADDR_WIDTH'(7): sel[7] = 1'b1;
      G_ADDR_WIDTH'(8): sel[8] = 1'b1;
      G_ADDR_WIDTH'(9): sel[9] = 1'b1;
      default:          sel    = '0;
    endcase
  end

  // r1: sw rw, hw rw; software wins a same-cycle collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q <= RST_R1;
    end else if (sw_wr && sel[0]) begin
      r1_q <= wdata;
    end else if (hwif_in_r1_f_we) begin
      r1_q <= hwif_in_r1_f_next;
    end
  end

  // r2: sw rw, hw read only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_q <= RST_R2;
    end else if (sw_wr && sel[1]) begin
      r2_q <= wdata;
    end
  end

  // r3: sw rw, hw write with active-low enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r3_q <= RST_R3;
    end else if (sw_wr && sel[2]) begin
      r3_q <= wdata;
    end else if (!hwif_in_r3_f_wel) begin
      r3_q <= hwif_in_r3_f_next;
    end
  end

  // r4: sw rw, invisible to hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r4_q <= RST_R4;
    end else if (sw_wr && sel[3]) begin
      r4_q <= wdata;
    end
  end

  // r5: sw read only, so only hardware can load it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r5_q <= RST_R5;
    end else if (hwif_in_r5_f_we) begin
      r5_q <= hwif_in_r5_f_next;
    end
  end

  // r9: sw write only, hw rw; software wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r9_q <= RST_R9;
    end else if (sw_wr && sel[8]) begin
      r9_q <= wdata;
    end else if (hwif_in_r9_f_we) begin
      r9_q <= hwif_in_r9_f_next;
    end
  end

  // r10: sw write only, hw read only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r10_q <= RST_R10;
    end else if (sw_wr && sel[9]) begin
      r10_q <= wdata;
    end
  end

  // Readback mux; write-only and unmapped slots read 0.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel[0]:  rd_mux = r1_q;
      sel[1]:  rd_mux = r2_q;
      sel[2]:  rd_mux = r3_q;
      sel[3]:  rd_mux = r4_q;
      sel[4]:  rd_mux = r5_q;
      sel[5]:  rd_mux = CONST_R6;
      sel[6]:  rd_mux = hwif_in_r7_f_next;
      sel[7]:  rd_mux = CONST_R8;
      default: rd_mux = '0;
    endcase
  end

  assign s_apb_pready  = access;
  assign s_apb_pslverr = 1'b0;
  assign s_apb_prdata  = sw_rd ? {24'b0, rd_mux}
                               : 32'b0;

  assign hwif_out_r1_f_value  = r1_q;
  assign hwif_out_r2_f_value  = r2_q;
  assign hwif_out_r5_f_value  = r5_q;
  assign hwif_out_r6_f_value  = CONST_R6;
  assign hwif_out_r9_f_value  = r9_q;
  assign hwif_out_r10_f_value = r10_q;

endmodule

// File: tb/tb_field_types_top.sv
// tb_field_types_top: directed checks of the
// field_types_top register map and APB timing.
module tb_field_types_top;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [7:0]  r1_next;
  logic        r1_we;
  logic [7:0]  r1_val;
  logic [7:0]  r2_val;
  logic [7:0]  r3_next;
  logic        r3_wel;
  logic [7:0]  r5_next;
  logic        r5_we;
  logic [7:0]  r5_val;
  logic [7:0]  r6_val;
  logic [7:0]  r7_next;
  logic [7:0]  r9_next;
  logic        r9_we;
  logic [7:0]  r9_val;
  logic [7:0]  r10_val;

  int checks;
  int errors;

  field_types_top #(.G_ADDR_WIDTH(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_apb_psel           (psel),
    .s_apb_penable        (penable),
    .s_apb_pwrite         (pwrite),
    .s_apb_pprot          (pprot),
    .s_apb_paddr          (paddr),
    .s_apb_pwdata         (pwdata),
    .s_apb_pstrb          (pstrb),
    .s_apb_pready         (pready),
    .s_apb_prdata         (prdata),
    .s_apb_pslverr        (pslverr),
    .hwif_in_r1_f_next    (r1_next),
    .hwif_in_r1_f_we      (r1_we),
    .hwif_out_r1_f_value  (r1_val),
    .hwif_out_r2_f_value  (r2_val),
    .hwif_in_r3_f_next    (r3_next),
    .hwif_in_r3_f_wel     (r3_wel),
    .hwif_in_r5_f_next    (r5_next),
    .hwif_in_r5_f_we      (r5_we),
    .hwif_out_r5_f_value  (r5_val),
    .hwif_out_r6_f_value  (r6_val),
    .hwif_in_r7_f_next    (r7_next),
    .hwif_in_r9_f_next    (r9_next),
    .hwif_in_r9_f_we      (r9_we),
    .hwif_out_r9_f_value  (r9_val),
    .hwif_out_r10_f_value (r10_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Full transfer: setup, access, idle. Reports how many
  // of those three cycles had pready high.
  task automatic apb_xfer(
    input  logic        wr,
    input  logic [3:0]  a,
    input  logic [7:0]  d,
    input  logic [3:0]  strb,
    output logic [31:0] rd,
    output int          rdy
  );
    rdy = 0;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = {24'hC3A5F0, d};
    pstrb   = strb;
    #1 if (pready) rdy++;
    @(negedge clk);
    penable = 1'b1;
    #1 if (pready) rdy++;
    rd = prdata;
    @(negedge clk);
    bus_idle();
    #1 if (pready) rdy++;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (pready !== 1'b0 || prdata !== 32'h0 ||
        pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus got rdy=%b rd=%h err=%b want 0 0 0",
               pready, prdata, pslverr);
    end
    checks++;
    if ({r1_val, r2_val, r5_val} !== {8'd10, 8'd20, 8'd50}) begin
      errors++;
      $display("FAIL reset_hw_a got %0d %0d %0d want 10 20 50",
               r1_val, r2_val, r5_val);
    end
    checks++;
    if ({r6_val, r9_val, r10_val} !== {8'd60, 8'd90, 8'd100}) begin
      errors++;
      $display("FAIL reset_hw_b got %0d %0d %0d want 60 90 100",
               r6_val, r9_val, r10_val);
    end
    bus_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_reads();
    logic [7:0]  exp [10];
    logic [31:0] rd;
    int          rdy;
    exp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50,
            8'd60, 8'h5A, 8'd80, 8'd0, 8'd0};
    for (int i = 0; i < 10; i++) begin
      apb_xfer(1'b0, 4'(i), 8'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== {24'h0, exp[i]} || rdy != 1) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h rdy=%0d want %h rdy=1",
                 i, rd, rdy, exp[i]);
      end
    end
  endtask

  task automatic test_sw_rw();
    logic [31:0] rd;
    int          rdy;
    logic [7:0]  wv [4];
    wv = '{8'd11, 8'd21, 8'd31, 8'd41};
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 4'(i), wv[i], 4'h1, rd, rdy);
      checks++;
      if (rd !== 32'h0 || rdy != 1) begin
        errors++;
        $display("FAIL sw_write[%0d] got rd=%h rdy=%0d want 0 rdy=1",
                 i, rd, rdy);
      end
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, 4'(i), 8'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== {24'h0, wv[i]}) begin
        errors++;
        $display("FAIL sw_readback[%0d] got %h want %h",
                 i, rd, wv[i]);
      end
    end
    checks++;
    if (r1_val !== 8'd11 || r2_val !== 8'd21) begin
      errors++;
      $display("FAIL sw_hwif got r1=%0d r2=%0d want 11 21",
               r1_val, r2_val);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd;
    int          rdy;
    apb_xfer(1'b1, 4'h0, 8'h77, 4'b1110, rd, rdy);
    apb_xfer(1'b0, 4'h0, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd11 || r1_val !== 8'd11) begin
      errors++;
      $display("FAIL strobe_off got rd=%0d hw=%0d want 11 11",
               rd, r1_val);
    end
  endtask

  task automatic test_read_only();
    logic [31:0] rd;
    int          rdy;
    apb_xfer(1'b1, 4'h4, 8'd51, 4'h1, rd, rdy);
    apb_xfer(1'b1, 4'h5, 8'd61, 4'h1, rd, rdy);
    apb_xfer(1'b1, 4'h7, 8'd81, 4'h1, rd, rdy);
    apb_xfer(1'b1, 4'hA, 8'hEE, 4'h1, rd, rdy);
    apb_xfer(1'b0, 4'h4, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd50 || r5_val !== 8'd50) begin
      errors++;
      $display("FAIL ro_r5 got rd=%0d hw=%0d want 50 50", rd, r5_val);
    end
    apb_xfer(1'b0, 4'h5, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd60 || r6_val !== 8'd60) begin
      errors++;
      $display("FAIL ro_r6 got rd=%0d hw=%0d want 60 60", rd, r6_val);
    end
    apb_xfer(1'b0, 4'h7, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd80) begin
      errors++;
      $display("FAIL ro_r8 got %0d want 80", rd);
    end
    for (int a = 10; a < 16; a++) begin
      apb_xfer(1'b0, 4'(a), 8'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== 32'h0 || rdy != 1 || pslverr !== 1'b0) begin
        errors++;
        $display("FAIL unmapped[%0d] got %h rdy=%0d want 0 rdy=1",
                 a, rd, rdy);
      end
    end
  endtask

  task automatic test_write_only();
    logic [31:0] rd;
    int          rdy;
    apb_xfer(1'b1, 4'h8, 8'd91, 4'h1, rd, rdy);
    apb_xfer(1'b1, 4'h9, 8'd101, 4'h1, rd, rdy);
    checks++;
    if (r9_val !== 8'd91 || r10_val !== 8'd101) begin
      errors++;
      $display("FAIL wo_hwif got r9=%0d r10=%0d want 91 101",
               r9_val, r10_val);
    end
    for (int a = 8; a < 10; a++) begin
      apb_xfer(1'b0, 4'(a), 8'h0, 4'h0, rd, rdy);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL wo_read[%0d] got %h want 0", a, rd);
      end
    end
  endtask

  task automatic test_hw_writes();
    logic [31:0] rd;
    int          rdy;
    @(negedge clk);
    r1_next = 8'd9;
    r1_we   = 1'b1;
    #1;
    checks++;
    if (r1_val !== 8'd11) begin
      errors++;
      $display("FAIL hw_r1_early got %0d want 11", r1_val);
    end
    @(negedge clk);
    r1_we = 1'b0;
    #1;
    checks++;
    if (r1_val !== 8'd9) begin
      errors++;
      $display("FAIL hw_r1_hwif got %0d want 9", r1_val);
    end
    apb_xfer(1'b0, 4'h0, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd9) begin
      errors++;
      $display("FAIL hw_r1_read got %0d want 9", rd);
    end
    @(negedge clk);
    r3_next = 8'd29;
    r3_wel  = 1'b0;
    @(negedge clk);
    r3_wel = 1'b1;
    apb_xfer(1'b0, 4'h2, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd29) begin
      errors++;
      $display("FAIL hw_r3_read got %0d want 29", rd);
    end
    @(negedge clk);
    r5_next = 8'd9;
    r5_we   = 1'b1;
    @(negedge clk);
    r5_we = 1'b0;
    apb_xfer(1'b0, 4'h4, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd9 || r5_val !== 8'd9) begin
      errors++;
      $display("FAIL hw_r5 got rd=%0d hw=%0d want 9 9", rd, r5_val);
    end
    @(negedge clk);
    r9_next = 8'd89;
    r9_we   = 1'b1;
    @(negedge clk);
    r9_we = 1'b0;
    #1;
    checks++;
    if (r9_val !== 8'd89) begin
      errors++;
      $display("FAIL hw_r9_hwif got %0d want 89", r9_val);
    end
    r7_next = 8'd70;
    apb_xfer(1'b0, 4'h6, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd70) begin
      errors++;
      $display("FAIL hw_r7_a got %0d want 70", rd);
    end
    r7_next = 8'd71;
    apb_xfer(1'b0, 4'h6, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd71) begin
      errors++;
      $display("FAIL hw_r7_b got %0d want 71", rd);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    int          rdy;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'h0;
    pwdata  = 32'h0000_0055;
    pstrb   = 4'h1;
    @(negedge clk);
    penable = 1'b1;
    r1_next = 8'hAA;
    r1_we   = 1'b1;
    @(negedge clk);
    bus_idle();
    r1_we = 1'b0;
    apb_xfer(1'b0, 4'h0, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'h55 || r1_val !== 8'h55) begin
      errors++;
      $display("FAIL collision got rd=%h hw=%h want 55 55",
               rd, r1_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'h1;
    pwdata  = 32'h0000_0033;
    pstrb   = 4'h1;
    @(negedge clk);
    penable = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wr_ready got %b want 1", pready);
    end
    @(negedge clk);
    penable = 1'b0;
    pwrite  = 1'b0;
    #1;
    checks++;
    if (pready !== 1'b0 || r2_val !== 8'h33) begin
      errors++;
      $display("FAIL b2b_setup got rdy=%b hw=%h want 0 33",
               pready, r2_val);
    end
    @(negedge clk);
    penable = 1'b1;
    #1;
    rd = prdata;
    checks++;
    if (pready !== 1'b1 || rd !== 32'h33) begin
      errors++;
      $display("FAIL b2b_rd got rdy=%b rd=%h want 1 33",
               pready, rd);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int          rdy;
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'h3;
    pwdata  = 32'h0000_0077;
    pstrb   = 4'h1;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    penable = 1'b1;
    #1;
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready got %b want 0", pready);
    end
    @(negedge clk);
    bus_idle();
    apb_xfer(1'b0, 4'h3, 8'h0, 4'h0, rd, rdy);
    checks++;
    if (rd !== 32'd40 || rdy != 1) begin
      errors++;
      $display("FAIL abort_r4 got %0d rdy=%0d want 40 rdy=1",
               rd, rdy);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pprot   = 3'b0;
    paddr   = 4'h0;
    pwdata  = 32'h0;
    pstrb   = 4'h0;
    r1_next = 8'h0;
    r1_we   = 1'b0;
    r3_next = 8'h0;
    r3_wel  = 1'b1;
    r5_next = 8'h0;
    r5_we   = 1'b0;
    r7_next = 8'h5A;
    r9_next = 8'h0;
    r9_we   = 1'b0;
    test_reset();
    test_reset_reads();
    test_sw_rw();
    test_strobe();
    test_read_only();
    test_write_only();
    test_hw_writes();
    test_collision();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
